// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder
//   Streaming LEGv8 assembler back-end. It takes one symbolic instruction per
//   in_valid/in_ready handshake and produces the 32-bit machine word one cycle
//   later, paired with the byte address it should be preloaded at.
//   The output stage is a single register slice with valid/ready backpressure.
//   Immediates that do not fit the selected format are dropped. A drop raises
//   a one-cycle err pulse and bumps a saturating counter.
//
// Ports
//   clk, reset           rising-edge clock, async active-high reset
//   clear                sync restart: address back to BASE_ADDR, err_cnt to 0
//   in_valid / in_ready  input handshake
//   in_op                0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 NOP
//   in_rd, in_rn, in_rm  register fields
//   in_imm               20-bit signed immediate (DT_address / CB offset)
//   out_valid/out_ready  output handshake
//   out_word, out_addr   encoded word and its byte address
//   err, err_cnt         drop pulse and saturating drop count
// ----------------------------------------------------------------------------
module instruction_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [19:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    logic              r_out_valid;
    logic [31:0]       r_out_word;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_cnt;

    logic        w_accept;
    logic        w_out_hs;
    logic        w_bad;
    logic        w_d_ok;
    logic        w_cb_ok;
    logic [31:0] w_word;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    // An imm fits in N signed bits when all bits above N-1 match bit N-1.
    // D format keeps 9 bits, CB format keeps 19 bits.
    assign w_d_ok  = (&in_imm[19:8]) || !(|in_imm[19:8]);
    assign w_cb_ok = (in_imm[19] == in_imm[18]);

    always_comb begin
        w_word = 32'h0000_0000;
        w_bad  = 1'b0;
        case (in_op)
            3'd0: w_word = {OPC_ADD, in_rm, 6'b0, in_rn, in_rd};
            3'd1: w_word = {OPC_SUB, in_rm, 6'b0, in_rn, in_rd};
            3'd2: w_word = {OPC_AND, in_rm, 6'b0, in_rn, in_rd};
            3'd3: w_word = {OPC_ORR, in_rm, 6'b0, in_rn, in_rd};
            3'd4: begin
                w_word = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
                w_bad  = !w_d_ok;
            end
            3'd5: begin
                w_word = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
                w_bad  = !w_d_ok;
            end
            3'd6: begin
                w_word = {OPC_CBZ, in_imm[18:0], in_rd};
                w_bad  = !w_cb_ok;
            end
            default: w_word = 32'h0000_0000;  // NOP ignores every field
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_word  <= 32'h0000_0000;
            r_out_addr  <= BASE_ADDR;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err <= w_accept && w_bad;

            // A new word may load on the same edge the old one is consumed.
            if (w_accept && !w_bad) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_word;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            // The address counts completed output handshakes. clear wins over
            // the increment, and a still-pending word is relabelled BASE_ADDR.
            if (clear)
                r_out_addr <= BASE_ADDR;
            else if (w_out_hs)
                r_out_addr <= r_out_addr + ADDR_W'(4);

            if (clear)
                r_err_cnt <= '0;
            else if (w_accept && w_bad && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
